// File: rtl/mod997_pkg.sv
// Shared constants, FSM state type and the term pre-reduce helper for the
// mod-997 residue accumulator slice. The modulus bounds every result, the
// residue width covers any LUT output, the frame holds one partial residue
// per 6-bit chunk of the 300-bit operand, and the counter is wide enough to
// index every term of a frame.
package mod997_pkg;

  localparam int unsigned MOD     = 997;
  localparam int unsigned RES_W   = 10;
  localparam int unsigned N_TERMS = 50;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // A LUT output can exceed the modulus by at most 1023-997, so one
  // conditional subtract brings any RES_W-bit value into 0..m-1.
  function automatic logic [RES_W-1:0] pre_reduce(input logic [RES_W-1:0] r,
                                                  input logic [RES_W-1:0] m);
    logic [RES_W-1:0] t;
    if (r >= m) begin
      t = r - m;
    end else begin
      t = r;
    end
    return t;
  endfunction

endpackage

// File: rtl/mod997_residue_accumulator_if.sv
// Stream interface of the residue accumulator.
//   in_valid/in_ready/in_residue          : one partial residue per handshake
//   out_valid/out_ready/out_residue       : completed frame result
//   out_range_err                         : some term of the frame was >= MOD
// slave  : the accumulator side
// master : the producer/consumer side (LUT array and result sink)
interface mod997_residue_accumulator_if;
  import mod997_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_residue;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_residue;
  logic             out_range_err;

  modport slave (
    input  in_valid, in_residue, out_ready,
    output in_ready, out_valid, out_residue, out_range_err
  );

  modport master (
    output in_valid, in_residue, out_ready,
    input  in_ready, out_valid, out_residue, out_range_err
  );

endinterface

// File: rtl/mod997_add.sv
// Combinational modular adder: sum = (a + b) mod MOD for a, b < MOD.
//   a, b : operands, each already reduced below MOD
//   sum  : reduced result
// The raw sum is below 2*MOD, so one extra bit and one conditional subtract
// are enough. Shared with the tree-reduction variant of the reducer.
module mod997_add #(
  parameter int unsigned MOD   = mod997_pkg::MOD,
  parameter int unsigned RES_W = mod997_pkg::RES_W
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum
);

  localparam logic [RES_W:0] MOD_W = (RES_W + 1)'(MOD);

  logic [RES_W:0] raw_s;

  // Wide add followed by a single conditional subtract of the modulus.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b};
    if (raw_s >= MOD_W) begin
      sum = RES_W'(raw_s - MOD_W);
    end else begin
      sum = raw_s[RES_W-1:0];
    end
  end

endmodule

// File: rtl/mod997_residue_accumulator.sv
// Serial mod-997 accumulator behind the 50 chunk residue LUTs.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, discards any partial frame
//   bus  : slave side of the residue stream (terms in, frame result out)
// Terms are accepted one per cycle in ACCUM; the N_TERMS-th accept latches
// the frame result and moves to DONE, which holds it until out_ready.
module mod997_residue_accumulator #(
  parameter int unsigned MOD     = mod997_pkg::MOD,
  parameter int unsigned RES_W   = mod997_pkg::RES_W,
  parameter int unsigned N_TERMS = mod997_pkg::N_TERMS,
  parameter int unsigned CNT_W   = mod997_pkg::CNT_W
) (
  input logic                           clk,
  input logic                           rst,
  mod997_residue_accumulator_if.slave   bus
);

  localparam logic [RES_W-1:0] MOD_V    = RES_W'(MOD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  mod997_pkg::state_e state_r;
  mod997_pkg::state_e state_nxt_s;

  logic [RES_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic [RES_W-1:0] out_residue_r;
  logic             out_range_err_r;

  logic [RES_W-1:0] term_s;
  logic [RES_W-1:0] sum_s;
  logic             term_err_s;
  logic             err_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic             release_s;

  // Handshake decode and term conditioning for the current cycle.
  always_comb begin
    accept_s   = bus.in_valid && (state_r == mod997_pkg::ACCUM);
    last_s     = (cnt_r == LAST_CNT);
    release_s  = bus.out_ready && (state_r == mod997_pkg::DONE);
    term_err_s = (bus.in_residue >= MOD_V);
    err_nxt_s  = err_r | term_err_s;
    term_s     = mod997_pkg::pre_reduce(bus.in_residue, MOD_V);
  end

  mod997_add #(
    .MOD   (MOD),
    .RES_W (RES_W)
  ) u_add (
    .a   (acc_r),
    .b   (term_s),
    .sum (sum_s)
  );

  // Next-state logic: the frame ends on the accept that sees the last count.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      mod997_pkg::ACCUM: begin
        if (accept_s && last_s) begin
          state_nxt_s = mod997_pkg::DONE;
        end else begin
          state_nxt_s = mod997_pkg::ACCUM;
        end
      end
      mod997_pkg::DONE: begin
        if (release_s) begin
          state_nxt_s = mod997_pkg::ACCUM;
        end else begin
          state_nxt_s = mod997_pkg::DONE;
        end
      end
      default: state_nxt_s = mod997_pkg::ACCUM;
    endcase
  end

  // State, running sum, term count, sticky error and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= mod997_pkg::ACCUM;
      acc_r           <= '0;
      cnt_r           <= '0;
      err_r           <= 1'b0;
      out_residue_r   <= '0;
      out_range_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        acc_r <= sum_s;
        err_r <= err_nxt_s;
        if (last_s) begin
          cnt_r           <= '0;
          out_residue_r   <= sum_s;
          out_range_err_r <= err_nxt_s;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else if (release_s) begin
        // Result consumed: open a fresh frame.
        acc_r <= '0;
        err_r <= 1'b0;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  // Ready/valid are pure decodes of the state register, so there is no
  // combinational path from out_ready to in_ready.
  assign bus.in_ready      = (state_r == mod997_pkg::ACCUM);
  assign bus.out_valid     = (state_r == mod997_pkg::DONE);
  assign bus.out_residue   = out_residue_r;
  assign bus.out_range_err = out_range_err_r;

endmodule

// File: tb/tb_mod997_residue_accumulator.sv
// Directed-plus-random bench for the mod-997 residue accumulator. Expected
// results come from plain integer arithmetic over each frame's term list.
module tb_mod997_residue_accumulator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod997_residue_accumulator_if bus_if ();

  mod997_residue_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int terms_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the frame in terms_q (with random bubbles), then check the result,
  // optionally stalling the consumer for hold_cycles cycles.
  task automatic run_frame(input string tag, input int gap_pct, input int hold_cycles);
    int   total = 0;
    int   exp_res;
    logic exp_err = 1'b0;
    int   idx = 0;
    int   budget = 0;
    logic rdy;
    logic early = 1'b0;
    logic [9:0] held_res;
    foreach (terms_q[i]) begin
      total += terms_q[i];
      if (terms_q[i] >= 997) exp_err = 1'b1;
    end
    exp_res = total % 997;
    bus_if.out_ready = (hold_cycles == 0);
    check({tag, "_start_ready"}, 32'(bus_if.in_ready), 32'd1);
    while (idx < 50 && budget < 1000) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        bus_if.in_valid   = 1'b0;
        bus_if.in_residue = 10'($urandom_range(0, 1023));
      end else begin
        bus_if.in_valid   = 1'b1;
        bus_if.in_residue = 10'(terms_q[idx]);
      end
      rdy = bus_if.in_ready;
      tick();
      budget++;
      if (bus_if.in_valid && rdy) idx++;
      if (idx < 50 && bus_if.out_valid !== 1'b0) early = 1'b1;
    end
    check({tag, "_accepts"}, 32'(idx), 32'd50);
    check({tag, "_no_early_valid"}, 32'(early), 32'd0);
    check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_in_ready_low"}, 32'(bus_if.in_ready), 32'd0);
    check({tag, "_residue"}, 32'(bus_if.out_residue), 32'(exp_res));
    check({tag, "_err"}, 32'(bus_if.out_range_err), 32'(exp_err));
    held_res = 10'(exp_res);
    // Offer junk terms while the result is pending; none may be consumed.
    bus_if.in_valid   = 1'b1;
    bus_if.in_residue = 10'($urandom_range(1, 1023));
    for (int h = 0; h < hold_cycles; h++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
      check({tag, "_hold_residue"}, 32'(bus_if.out_residue), 32'(held_res));
      check({tag, "_hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_out_residue"}, 32'(bus_if.out_residue), 32'd0);
    check({tag, "_out_err"}, 32'(bus_if.out_range_err), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.in_residue = 10'd0;
    bus_if.out_ready  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_values("reset");

    // All-zero frame.
    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(0);
    run_frame("zeros", 0, 0);

    // 1..50 with random bubbles: 1275 mod 997.
    terms_q.delete();
    for (int i = 1; i <= 50; i++) terms_q.push_back(i);
    run_frame("ramp_gaps", 40, 0);

    // One out-of-range term.
    terms_q.delete();
    terms_q.push_back(1000);
    for (int i = 0; i < 49; i++) terms_q.push_back(0);
    run_frame("range_err", 0, 0);

    // Error flag must not leak into the next frame.
    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(0);
    run_frame("zeros_after_err", 0, 0);

    // Random terms (including out-of-range ones) with a stalled consumer.
    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(int'($urandom_range(0, 1023)));
    run_frame("rand_hold", 0, 5);

    // Random in-range terms with bubbles.
    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(int'($urandom_range(0, 996)));
    run_frame("rand_gaps", 30, 0);

    // All 996: 50*(-1) mod 997 = 947.
    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(996);
    run_frame("all_996", 0, 0);

    // Mid-frame reset after 20 terms of 5.
    bus_if.in_valid   = 1'b1;
    bus_if.in_residue = 10'd5;
    repeat (20) tick();
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midframe_reset");

    terms_q.delete();
    for (int i = 0; i < 50; i++) terms_q.push_back(1);
    run_frame("ones_after_reset", 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
